// File: rtl/mem_responder.sv
// mem_responder: dual-port 32-bit word memory responder (read-only instruction port, byte-strobed data port)
// Ports: clk/rst_n (async active-low); instr_read/instr_addr -> instr_out/instr_err;
// data_read/data_write/data_addr/data_in -> data_out/data_err. Reads land READ_LATENCY edges after sampling.
module mem_responder #(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  output logic        instr_err,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_err
);
  typedef struct packed {
    logic        iv;
    logic        ie;
    logic [31:0] id;
    logic        dv;
    logic        de;
    logic        dw;
    logic [31:0] dd;
  } stage_t;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] i_idx, d_idx;
  logic i_ok, d_rng, d_wbad, pulse;
  stage_t n, t;
  assign i_idx  = instr_addr[ADDR_WIDTH+1:2];
  assign d_idx  = data_addr[ADDR_WIDTH+1:2];
  assign i_ok   = instr_addr[31:ADDR_WIDTH+2] == '0 && instr_addr[1:0] == 2'b00;
  assign d_rng  = data_addr[31:ADDR_WIDTH+2] == '0;
  assign d_wbad = |data_write && !(d_rng && data_addr[1:0] == 2'b00);
  // Array is read before this edge's write lands, giving read-first collisions.
  always_comb begin
    n.iv = instr_read;
    n.ie = !i_ok;
    n.id = i_ok ? mem[i_idx] : '0;
    n.dv = data_read;
    n.de = !d_rng || d_wbad;
    n.dw = d_wbad;
    n.dd = d_rng ? mem[d_idx] : '0;
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (data_write[k] && !d_wbad) mem[d_idx][8*k +: 8] <= data_in[8*k +: 8];
  end
  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign t = n;
    end else begin : g_pipe
      localparam int D = READ_LATENCY - 1;
      stage_t p [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) p[i] <= '0;
        end else begin
          p[0] <= n;
          for (int i = 1; i < D; i++) p[i] <= p[i-1];
        end
      end
      assign t = p[D-1];
    end
  endgenerate
  // pulse marks a data_err raised only by a rejected write, which lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out <= '0;
      instr_err <= 1'b0;
      data_out  <= '0;
      data_err  <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      if (t.iv) begin
        instr_out <= t.id;
        instr_err <= t.ie;
      end
      if (t.dv) begin
        data_out <= t.dd;
        data_err <= t.de;
        pulse    <= 1'b0;
      end else if (t.dw) begin
        data_err <= 1'b1;
        pulse    <= 1'b1;
      end else if (pulse) begin
        data_err <= 1'b0;
        pulse    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector bench for mem_responder at latency 1 and latency 3
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic ir1, dr1, ir3, dr3, ie1, de1, ie3, de3;
  logic [3:0] dw1, dw3;
  logic [31:0] ia1, da1, di1, io1, do1, ia3, da3, di3, io3, do3;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_responder u1 (
    .clk(clk), .rst_n(rst_n),
    .instr_read(ir1), .instr_addr(ia1), .instr_out(io1), .instr_err(ie1),
    .data_read(dr1), .data_write(dw1), .data_addr(da1), .data_in(di1),
    .data_out(do1), .data_err(de1)
  );
  mem_responder #(.ADDR_WIDTH(14), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .instr_read(ir3), .instr_addr(ia3), .instr_out(io3), .instr_err(ie3),
    .data_read(dr3), .data_write(dw3), .data_addr(da3), .data_in(di3),
    .data_out(do3), .data_err(de3)
  );
  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [3:0]  dw;
    logic [31:0] da;
    logic [31:0] di;
    logic [31:0] eio;
    logic        eie;
    logic [31:0] edo;
    logic        ede;
  } vec_t;
  vec_t v [19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{0, 32'h0,       0, 4'hf, 32'h100,     32'hDEADBEEF, 32'h0,        0, 32'h0,        0};
    v[1]  = '{0, 32'h0,       1, 4'h0, 32'h100,     32'h0,        32'h0,        0, 32'hDEADBEEF, 0};
    v[2]  = '{0, 32'h0,       0, 4'hf, 32'h40,      32'h11223344, 32'h0,        0, 32'hDEADBEEF, 0};
    v[3]  = '{0, 32'h0,       0, 4'h5, 32'h40,      32'hAABBCCDD, 32'h0,        0, 32'hDEADBEEF, 0};
    v[4]  = '{0, 32'h0,       1, 4'h0, 32'h40,      32'h0,        32'h0,        0, 32'h11BB33DD, 0};
    v[5]  = '{0, 32'h0,       0, 4'hf, 32'h40,      32'h12345678, 32'h0,        0, 32'h11BB33DD, 0};
    v[6]  = '{1, 32'h40,      1, 4'hf, 32'h40,      32'h0,        32'h12345678, 0, 32'h12345678, 0};
    v[7]  = '{1, 32'h40,      0, 4'h0, 32'h0,       32'h0,        32'h0,        0, 32'h12345678, 0};
    v[8]  = '{1, 32'h2,       0, 4'h0, 32'h0,       32'h0,        32'h0,        1, 32'h12345678, 0};
    v[9]  = '{1, 32'h100,     0, 4'h0, 32'h0,       32'h0,        32'hDEADBEEF, 0, 32'h12345678, 0};
    v[10] = '{0, 32'h0,       0, 4'hf, 32'h40000,   32'hFFFFFFFF, 32'hDEADBEEF, 0, 32'h12345678, 1};
    v[11] = '{0, 32'h0,       0, 4'h0, 32'h0,       32'h0,        32'hDEADBEEF, 0, 32'h12345678, 0};
    v[12] = '{0, 32'h0,       1, 4'h0, 32'h40000,   32'h0,        32'hDEADBEEF, 0, 32'h0,        1};
    v[13] = '{0, 32'h0,       0, 4'h0, 32'h0,       32'h0,        32'hDEADBEEF, 0, 32'h0,        1};
    v[14] = '{0, 32'h0,       1, 4'h0, 32'h101,     32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    v[15] = '{0, 32'h0,       1, 4'hf, 32'h102,     32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 1};
    v[16] = '{0, 32'h0,       1, 4'h0, 32'h100,     32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    v[17] = '{1, 32'h40000,   0, 4'h0, 32'h0,       32'h0,        32'h0,        1, 32'hDEADBEEF, 0};
    v[18] = '{0, 32'h0,       1, 4'h0, 32'h40,      32'h0,        32'h0,        1, 32'h0,        0};
    {ir1, dr1, dw1, ia1, da1, di1} = '0;
    {ir3, dr3, dw3, ia3, da3, di3} = '0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_io1", io1, 32'h0);
    chk("rst_ie1", {31'h0, ie1}, 32'h0);
    chk("rst_do1", do1, 32'h0);
    chk("rst_de1", {31'h0, de1}, 32'h0);
    chk("rst_io3", io3, 32'h0);
    chk("rst_do3", do3, 32'h0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      ir1 = v[i].ir; ia1 = v[i].ia; dr1 = v[i].dr; dw1 = v[i].dw; da1 = v[i].da; di1 = v[i].di;
      tick();
      chk($sformatf("v%0d_io", i), io1, v[i].eio);
      chk($sformatf("v%0d_ie", i), {31'h0, ie1}, {31'h0, v[i].eie});
      chk($sformatf("v%0d_do", i), do1, v[i].edo);
      chk($sformatf("v%0d_de", i), {31'h0, de1}, {31'h0, v[i].ede});
    end
    {ir1, dr1, dw1, ia1, da1, di1} = '0;
    for (int i = 0; i < 3; i++) begin
      dw3 = 4'hf; da3 = 32'(i * 4); di3 = 32'h0A0A0000 + 32'(i);
      tick();
    end
    dw3 = 4'h0;
    ir3 = 1'b1; ia3 = 32'h0;
    tick();
    chk("l3_e1", io3, 32'h0);
    ia3 = 32'h4;
    tick();
    chk("l3_e2", io3, 32'h0);
    ia3 = 32'h8;
    tick();
    chk("l3_e3", io3, 32'h0A0A0000);
    ir3 = 1'b0;
    tick();
    chk("l3_e4", io3, 32'h0A0A0001);
    tick();
    chk("l3_e5", io3, 32'h0A0A0002);
    tick();
    chk("l3_hold", io3, 32'h0A0A0002);
    ir3 = 1'b1; ia3 = 32'h4; dr3 = 1'b1; da3 = 32'h8;
    tick();
    ir3 = 1'b0; dr3 = 1'b0; dw3 = 4'hf; da3 = 32'hC; di3 = 32'h55;
    tick();
    dw3 = 4'h0;
    rst_n = 1'b0;
    #1;
    chk("async_io3", io3, 32'h0);
    chk("async_do3", do3, 32'h0);
    chk("async_ie1", {31'h0, ie1}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stale_io3_%0d", i), io3, 32'h0);
      chk($sformatf("stale_do3_%0d", i), do3, 32'h0);
    end
    dr3 = 1'b1; da3 = 32'hC;
    tick();
    dr3 = 1'b0;
    tick();
    chk("persist_e2", do3, 32'h0);
    tick();
    chk("persist_e3", do3, 32'h55);
    chk("persist_err", {31'h0, de3}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Dual-port word memory that acts as the responder for the CPU's instruction-fetch and data-access interface.
- Instruction port is read-only. Data port reads, and writes with byte-lane strobes.
- Each read returns its data after a fixed, parameterized number of cycles. Out-of-range and misaligned accesses are reported on per-port error flags.
- Sits between the CPU core and the testbench or system top, replacing the behavioural memory models.

Parameters:
- ADDR_WIDTH, 14, number of word-index bits; capacity is 2^ADDR_WIDTH 32-bit words (64 KiB by default).
- READ_LATENCY, 1, clock edges from read sampling to data valid on the output; legal range 1..4.

Ports:
- clk  input  1  single clock; all sampling on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- instr_read  input  1  instruction read request, sampled each edge.
- instr_addr  input  32  instruction byte address.
- instr_out  output  32  instruction read data.
- instr_err  output  1  error flag aligned with instr_out.
- data_read  input  1  data read request, sampled each edge.
- data_write  input  4  byte write strobes; bit k writes byte lane k (bits [8k+7:8k]).
- data_addr  input  32  data byte address.
- data_in  input  32  write data.
- data_out  output  32  data read data.
- data_err  output  1  error flag aligned with data_out.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0):
  - instr_out, data_out, instr_err and data_err go to 0 immediately.
  - All read-pipeline valid bits are cleared.
  - Memory array contents are not reset.
- Reset mid-operation: reads in flight are discarded and produce no output after release. A write sampled on the edge before reset assertion has already completed and stays in the array.
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2].
  - In range: addr[31:ADDR_WIDTH+2] == 0.
  - Aligned: addr[1:0] == 0.
- Instruction read: sampled on an edge with instr_read=1.
  - After READ_LATENCY edges, instr_out = mem[index] and instr_err = 0.
  - If out of range or misaligned: instr_out = 0 and instr_err = 1.
- Data read: sampled on an edge with data_read=1.
  - addr[1:0] is ignored (word read).
  - Out of range: data_out = 0 and data_err = 1 after READ_LATENCY edges.
- Data write: on an edge with data_write != 0, only the selected byte lanes of mem[index] are updated from data_in.
  - Write completes in that edge; no latency, no response.
  - Out of range or misaligned: write suppressed for all lanes. data_err pulses for 1 cycle, READ_LATENCY edges later. If a data read is sampled on that same edge, its data_err result is forced to 1 as well.
- Output hold:
  - Outputs change only when a sampled read reaches the pipeline end; otherwise they hold their last value.
  - Error flags follow the same hold rule, except a write-error pulse clears on the next edge unless a new error arrives.
- Throughput: one read per port per cycle, fully pipelined. Back-to-back reads complete back-to-back, in order.
- Collisions (read-first):
  - A data write on the same edge as a data read or instruction read of the same word returns the pre-write word to the reader.
  - The write is visible to reads sampled on later edges.
- Both ports may access the same word in the same cycle with no stall.
- data_write == 0 and data_read == 0: no array or output activity.
- Width rules: no arithmetic beyond index slicing. The strobe merge is per lane.

Test Plan:
- Reset with rst_n=0 mid-stream while a read is in flight, then release -> all outputs 0 during reset; no stale read completes after release.
- data_write=4'hf, data_addr=32'h100, data_in=32'hDEADBEEF; next cycle data_read=1 at 32'h100 -> data_out=32'hDEADBEEF and data_err=0 after READ_LATENCY edges.
- Prior word 32'h11223344 at 32'h40; data_write=4'b0101, data_in=32'hAABBCCDD, then read 32'h40 -> data_out=32'h11BB33DD.
- Same-edge data_write=4'hf of 32'h0 to 32'h40 with instr_read at 32'h40 (old 32'h12345678) -> instr_out=32'h12345678; a following instruction read returns 32'h0.
- instr_addr=32'h2 -> instr_out=0, instr_err=1. data_write=4'hf at 32'h0004_0000 (ADDR_WIDTH=14) -> no array change, data_err pulses 1 cycle.
- READ_LATENCY=3, instruction reads issued every cycle at 0x0, 0x4, 0x8 -> instr_out presents the three words on 3 consecutive cycles, starting 3 edges after the first request.
